tx_frame_arbiter: RTL and testbench
===================================

Name: tx_frame_arbiter

Overview:
- Shares the single QPSK packet packer between two payload sources: s00 = control/beacon, s01 = user data.
- Grants one source at a time and forwards exactly NUM_DATA words atomically on m00 with tlast on the final word.
- Enforces a minimum inter-frame gap and repairs malformed source packets (wrong length, stalls) so the packer always receives well-formed packets.
- Sits between the source DMA/FIFOs and the packer's AXIS slave port.

Parameters:
- C_AXIS_TDATA_WIDTH, 32: data width of all AXIS ports.
- NUM_DATA, 4: words per packet; must match the packer.
- GAP_CYCLES, 16: idle cycles after the final accepted beat before the next grant; 0 means none.
- MAX_STALL, 1024: consecutive cycles without granted-source tvalid before a packet is aborted.
- PRIO_S00, 0: 0 = round-robin; 1 = s00 strict priority.

Ports:
- s00_axis_aclk  in  1  sole clock for all interfaces
- s00_axis_areset  in  1  synchronous, active-high reset
- s00_axis_tdata / s01_axis_tdata  in  C_AXIS_TDATA_WIDTH  source payload
- s00_axis_tvalid, s00_axis_tlast / s01_axis_tvalid, s01_axis_tlast  in  1 each  source handshake
- s00_axis_tready / s01_axis_tready  out  1 each
- m00_axis_tdata  out  C_AXIS_TDATA_WIDTH  to packer
- m00_axis_tvalid, m00_axis_tlast  out  1 each
- m00_axis_tready  in  1
- m00_axis_tuser  out  1  source id of current packet
- pkt_count_0 / pkt_count_1  out  16 each  completed packets per source, wrapping
- err_count  out  8  repaired/aborted packets, saturates at 255
- led  out  3  current state encoding

Behaviour:
- Interface: one clock (s00_axis_aclk); reset s00_axis_areset is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; last_grant = 1, so s01 has just been served and s00 wins the first tie.
- Reset mid-packet: the partial packet is abandoned and m00_axis_tvalid is 0 on the cycle after reset is sampled.
- States: IDLE, FWD, FLUSH, DISCARD, GAP.
- IDLE: requests = {s01_axis_tvalid, s00_axis_tvalid}.
  - Round-robin: on a tie, grant the source not equal to last_grant.
  - PRIO_S00=1: s00 always wins.
  - The grant registers this cycle and the state moves to FWD; tready stays 0 in IDLE.
- Output stage: one registered stage, 1-cycle latency source to m00.
  - Granted tready = (~m00_axis_tvalid | m00_axis_tready).
  - Non-granted tready is always 0.
- FWD:
  - word_cnt increments per accepted source beat.
  - m00_axis_tlast is asserted on word NUM_DATA-1 regardless of source tlast.
  - Normal completion: source tlast arrives on word NUM_DATA-1; go to GAP once the final m00 beat is accepted.
  - Early source tlast (word k < NUM_DATA-1): forward word k with m00 tlast=0, go to FLUSH, err_count+1.
  - Missing source tlast at word NUM_DATA-1: force m00 tlast, err_count+1, go to DISCARD.
  - Watchdog: counts consecutive granted cycles with source tvalid=0 and clears on any source beat. At MAX_STALL, go to FLUSH with err_count+1.
- FLUSH: emit zero words on m00 until the total reaches NUM_DATA (tlast on the last), honouring m00_axis_tready; then GAP.
- DISCARD:
  - m00 idle; granted tready=1.
  - Drop source beats until tvalid&tlast, then GAP.
  - Watchdog applies here too; expiry goes to GAP with no extra err_count increment.
- GAP: count GAP_CYCLES, then IDLE. With GAP_CYCLES=0, go straight to IDLE.
- pkt_count_N increments on m00 tvalid&tready&tlast with tuser=N, including repaired packets.
- err_count: at most one increment per packet.
- Backpressure: m00_axis_tdata/tuser/tlast hold stable while tvalid=1 and tready=0.
- last_grant updates at grant time.

Decomposition:
- Package tx_arb_pkg holds:
  - state enum {IDLE, FWD, FLUSH, DISCARD, GAP} with explicit 3-bit encoding, also used for led;
  - src_id_t (1 bit);
  - widths CNT_W=16 and ERR_W=8.
- Sub-module rr_arbiter2: 2-request arbiter with a priority-mode input. Combinational grant plus registered last_grant, updated on an accept strobe.

Test Plan:
- s00 sends 4 words 0x11..0x14 with tlast on the 4th, m00_tready=1 → m00 shows 0x11..0x14, tlast on 0x14, tuser=0, pkt_count_0=1; no new grant for 16 cycles after.
- s00 and s01 both continuously valid, PRIO_S00=0, 4 packets → grant order s00, s01, s00, s01; pkt_count_0=2, pkt_count_1=2.
- s01 tlast on word 2 of 4 (data A, B) → m00 A, B, 0, 0 with tlast on the 4th word; err_count=1.
- s00 sends 6 words with no tlast until word 6 → m00 gets 4 words with forced tlast; words 5–6 are dropped; err_count=1; next grant only after word 6.
- s00 sends 1 word, then tvalid=0 for 1024 cycles → FLUSH emits 3 zero words with tlast; err_count=1.
- m00_tready toggles 1/0 every cycle during a packet, with reset asserted at word 2 → data is stable while stalled; after reset all outputs are 0, state IDLE, counters 0.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the tx frame arbiter.
//   state_t  : FSM states; the same encoding is driven onto the led output
//   src_id_t : payload source identifier (0 = control/beacon, 1 = user data)
//   CNT_W    : width of the per-source completed-packet counters
//   ERR_W    : width of the saturating repaired/aborted packet counter
package tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FWD     = 3'd1,
        FLUSH   = 3'd2,
        DISCARD = 3'd3,
        GAP     = 3'd4
    } state_t;

    typedef logic src_id_t;

    localparam int CNT_W = 16;
    localparam int ERR_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request arbiter.
//   clk, srst     : clock and synchronous active-high reset
//   i_req[1:0]    : request per source
//   i_prio_s00    : 1 = source 0 wins whenever it requests, 0 = round-robin
//   i_accept      : strobe; the current grant is taken and remembered
//   o_grant_valid : at least one request present
//   o_grant_id    : combinational winner
// The remembered winner starts at 1 so source 0 wins the first tie.
module rr_arbiter2
    import tx_arb_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] i_req,
    input  logic       i_prio_s00,
    input  logic       i_accept,
    output logic       o_grant_valid,
    output src_id_t    o_grant_id
);

    src_id_t r_last_grant;

    always_comb begin
        o_grant_valid = |i_req;
        o_grant_id    = 1'b0;
        if (i_req[0] && i_req[1]) begin
            o_grant_id = i_prio_s00 ? 1'b0 : ~r_last_grant;
        end else if (i_req[1]) begin
            o_grant_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_last_grant <= 1'b1;
        end else if (i_accept && o_grant_valid) begin
            r_last_grant <= o_grant_id;
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Shares the QPSK packet packer between two AXIS payload sources and always
// hands it well-formed packets of exactly NUM_DATA words.
//   s00_axis_aclk / s00_axis_areset : sole clock, synchronous active-high reset
//   s00_axis_* : control/beacon source (tuser id 0)
//   s01_axis_* : user data source (tuser id 1)
//   m00_axis_* : registered output to the packer, tuser = source id
//   pkt_count_0/1 : completed packets per source (wrapping)
//   err_count     : repaired or aborted packets (saturating)
//   led           : current FSM state encoding
module tx_frame_arbiter
    import tx_arb_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int NUM_DATA           = 4,
    parameter int GAP_CYCLES         = 16,
    parameter int MAX_STALL          = 1024,
    parameter int PRIO_S00           = 0
) (
    input  logic                          s00_axis_aclk,
    input  logic                          s00_axis_areset,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                          s00_axis_tvalid,
    input  logic                          s00_axis_tlast,
    output logic                          s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s01_axis_tdata,
    input  logic                          s01_axis_tvalid,
    input  logic                          s01_axis_tlast,
    output logic                          s01_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                          m00_axis_tvalid,
    output logic                          m00_axis_tlast,
    input  logic                          m00_axis_tready,
    output logic                          m00_axis_tuser,
    output logic [CNT_W-1:0]              pkt_count_0,
    output logic [CNT_W-1:0]              pkt_count_1,
    output logic [ERR_W-1:0]              err_count,
    output logic [2:0]                    led
);

    localparam int WCNT_W  = $clog2(NUM_DATA + 1);
    localparam int STALL_W = $clog2(MAX_STALL + 1);
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [WCNT_W-1:0]  WORDS      = WCNT_W'(NUM_DATA);
    localparam logic [WCNT_W-1:0]  LAST_IDX   = WCNT_W'(NUM_DATA - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MAX_STALL - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    // A zero gap skips the GAP state entirely.
    localparam state_t AFTER_PKT = (GAP_CYCLES == 0) ? IDLE : GAP;

    wire clk  = s00_axis_aclk;
    wire srst = s00_axis_areset;

    state_t                  r_state, w_state_next;
    src_id_t                 r_grant, w_grant_next;
    logic [WCNT_W-1:0]       r_word_cnt, w_word_cnt_next;
    logic [STALL_W-1:0]      r_stall_cnt, w_stall_cnt_next;
    logic [GAP_W-1:0]        r_gap_cnt, w_gap_cnt_next;
    logic [ERR_W-1:0]        r_err_cnt;

    logic [C_AXIS_TDATA_WIDTH-1:0] r_m_tdata;
    logic                          r_m_tvalid;
    logic                          r_m_tlast;
    src_id_t                       r_m_tuser;

    logic                          w_grant_valid;
    src_id_t                       w_grant_id;
    logic                          w_arb_accept;
    logic                          w_err_inc;
    logic                          w_s_tready;
    logic                          w_load;
    logic [C_AXIS_TDATA_WIDTH-1:0] w_load_data;
    logic                          w_load_last;
    logic                          w_out_free;
    logic                          w_stall_expire;
    logic                          w_m_fire_last;
    logic [C_AXIS_TDATA_WIDTH-1:0] w_src_tdata;
    logic                          w_src_tvalid;
    logic                          w_src_tlast;
    logic [1:0][CNT_W-1:0]         w_pkt_cnt;

    rr_arbiter2 u_arb (
        .clk           (clk),
        .srst          (srst),
        .i_req         ({s01_axis_tvalid, s00_axis_tvalid}),
        .i_prio_s00    (PRIO_S00 != 0),
        .i_accept      (w_arb_accept),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    assign w_src_tdata    = r_grant ? s01_axis_tdata  : s00_axis_tdata;
    assign w_src_tvalid   = r_grant ? s01_axis_tvalid : s00_axis_tvalid;
    assign w_src_tlast    = r_grant ? s01_axis_tlast  : s00_axis_tlast;
    // The output register can take a new word when empty or draining now.
    assign w_out_free     = ~r_m_tvalid | m00_axis_tready;
    assign w_stall_expire = (r_stall_cnt == STALL_LAST) && !w_src_tvalid;
    assign w_m_fire_last  = r_m_tvalid && m00_axis_tready && r_m_tlast;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_grant_next     = r_grant;
        w_word_cnt_next  = r_word_cnt;
        w_stall_cnt_next = r_stall_cnt;
        w_gap_cnt_next   = '0;
        w_arb_accept     = 1'b0;
        w_err_inc        = 1'b0;
        w_s_tready       = 1'b0;
        w_load           = 1'b0;
        w_load_data      = '0;
        w_load_last      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_grant_next     = w_grant_id;
                    w_arb_accept     = 1'b1;
                    w_word_cnt_next  = '0;
                    w_stall_cnt_next = '0;
                    w_state_next     = FWD;
                end
            end

            FWD: begin
                if (r_word_cnt == WORDS) begin
                    // Every word is staged; leave once the last one drains.
                    if (w_out_free) begin
                        w_state_next = AFTER_PKT;
                    end
                end else begin
                    w_s_tready = w_out_free;
                    if (w_src_tvalid) begin
                        w_stall_cnt_next = '0;
                        if (w_out_free) begin
                            w_load          = 1'b1;
                            w_load_data     = w_src_tdata;
                            w_load_last     = (r_word_cnt == LAST_IDX);
                            w_word_cnt_next = r_word_cnt + 1'b1;
                            if (r_word_cnt == LAST_IDX) begin
                                // Overlong packet: tlast is forced, rest dropped.
                                if (!w_src_tlast) begin
                                    w_err_inc    = 1'b1;
                                    w_state_next = DISCARD;
                                end
                            end else if (w_src_tlast) begin
                                // Short packet: pad with zeros.
                                w_err_inc    = 1'b1;
                                w_state_next = FLUSH;
                            end
                        end
                    end else if (w_stall_expire) begin
                        w_err_inc        = 1'b1;
                        w_stall_cnt_next = '0;
                        w_state_next     = FLUSH;
                    end else begin
                        w_stall_cnt_next = r_stall_cnt + 1'b1;
                    end
                end
            end

            FLUSH: begin
                if (r_word_cnt == WORDS) begin
                    if (w_out_free) begin
                        w_state_next = AFTER_PKT;
                    end
                end else if (w_out_free) begin
                    w_load          = 1'b1;
                    w_load_last     = (r_word_cnt == LAST_IDX);
                    w_word_cnt_next = r_word_cnt + 1'b1;
                end
            end

            DISCARD: begin
                w_s_tready = 1'b1;
                if (w_src_tvalid) begin
                    w_stall_cnt_next = '0;
                    if (w_src_tlast) begin
                        w_state_next = AFTER_PKT;
                    end
                end else if (w_stall_expire) begin
                    // Packet already counted as an error when it was cut short.
                    w_state_next = AFTER_PKT;
                end else begin
                    w_stall_cnt_next = r_stall_cnt + 1'b1;
                end
            end

            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_grant     <= 1'b0;
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
            r_gap_cnt   <= '0;
            r_err_cnt   <= '0;
            r_m_tdata   <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_m_tuser   <= 1'b0;
        end else begin
            r_grant     <= w_grant_next;
            r_word_cnt  <= w_word_cnt_next;
            r_stall_cnt <= w_stall_cnt_next;
            r_gap_cnt   <= w_gap_cnt_next;
            if (w_err_inc) begin
                r_err_cnt <= sat_inc_err(r_err_cnt);
            end
            // Payload fields only change on load, so they hold under backpressure.
            if (w_load) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_load_data;
                r_m_tlast  <= w_load_last;
                r_m_tuser  <= r_grant;
            end else if (m00_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pkt_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (srst) begin
                    r_cnt <= '0;
                end else if (w_m_fire_last && (r_m_tuser == 1'(gi))) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_pkt_cnt[gi] = r_cnt;
        end
    endgenerate

    assign s00_axis_tready = w_s_tready && (r_grant == 1'b0);
    assign s01_axis_tready = w_s_tready && (r_grant == 1'b1);
    assign m00_axis_tdata  = r_m_tdata;
    assign m00_axis_tvalid = r_m_tvalid;
    assign m00_axis_tlast  = r_m_tlast;
    assign m00_axis_tuser  = r_m_tuser;
    assign pkt_count_0     = w_pkt_cnt[0];
    assign pkt_count_1     = w_pkt_cnt[1];
    assign err_count       = r_err_cnt;
    assign led             = r_state;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter. A packet-level model predicts the
// words the packer must see for every source packet (pad short ones with
// zeros, cut long ones at NUM_DATA, zero-fill after a watchdog abort) and the
// packet/error counters; a monitor collects what m00 actually delivers.
module tb_tx_frame_arbiter;
    import tx_arb_pkg::*;

    localparam int DW   = 32;
    localparam int ND   = 4;
    localparam int GAPC = 16;
    localparam int MAXS = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic          s0_tvalid, s0_tlast, s0_tready;
    logic          s1_tvalid, s1_tlast, s1_tready;
    logic          m_tvalid, m_tlast, m_tready, m_tuser;
    logic [15:0]   pkt0, pkt1;
    logic [7:0]    errc;
    logic [2:0]    led;

    always #5 clk = ~clk;

    tx_frame_arbiter #(
        .C_AXIS_TDATA_WIDTH(DW), .NUM_DATA(ND), .GAP_CYCLES(GAPC),
        .MAX_STALL(MAXS), .PRIO_S00(0)
    ) dut (
        .s00_axis_aclk(clk),        .s00_axis_areset(rst),
        .s00_axis_tdata(s0_tdata),  .s00_axis_tvalid(s0_tvalid),
        .s00_axis_tlast(s0_tlast),  .s00_axis_tready(s0_tready),
        .s01_axis_tdata(s1_tdata),  .s01_axis_tvalid(s1_tvalid),
        .s01_axis_tlast(s1_tlast),  .s01_axis_tready(s1_tready),
        .m00_axis_tdata(m_tdata),   .m00_axis_tvalid(m_tvalid),
        .m00_axis_tlast(m_tlast),   .m00_axis_tready(m_tready),
        .m00_axis_tuser(m_tuser),
        .pkt_count_0(pkt0),         .pkt_count_1(pkt1),
        .err_count(errc),           .led(led)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    beat_t act_q[$];
    beat_t exp_q[$];
    int    gap_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pkt[2];
    int m_err;
    bit m_last;

    int rmode = 0;  // m00 tready: 0 always high, 1 random, 2 toggling

    task automatic check(input string tag, input logic [63:0] actv, input logic [63:0] expv);
        n_checks++;
        if (actv !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, actv, expv);
        end
    endtask

    task automatic set_src(input int src, input logic v, input logic [DW-1:0] d, input logic l);
        if (src == 0) begin
            s0_tvalid = v; s0_tdata = d; s0_tlast = l;
        end else begin
            s1_tvalid = v; s1_tdata = d; s1_tlast = l;
        end
    endtask

    // Returns just after the clock edge on which the presented word was taken.
    task automatic wait_hs(input int src);
        int   t;
        logic rdy;
        t = 0;
        forever begin
            @(negedge clk);
            rdy = (src == 0) ? s0_tready : s1_tready;
            if (rdy) break;
            t++;
            if (t > 5000) begin
                check("hs_timeout", 64'(rdy), 64'(1));
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // n words base..base+n-1, tlast on word n; stall_k>0 stops after stall_k
    // words and goes silent past the watchdog limit.
    task automatic drive_pkt(input int src, input int n, input int stall_k,
                             input int bub_max, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            if (stall_k > 0 && i == stall_k) begin
                set_src(src, 1'b0, '0, 1'b0);
                repeat (MAXS + 16) @(posedge clk);
                #1;
                return;
            end
            if (i > 0 && bub_max > 0) begin
                int b;
                b = $urandom_range(bub_max, 0);
                if (b > 0) begin
                    set_src(src, 1'b0, '0, 1'b0);
                    repeat (b) @(posedge clk);
                    #1;
                end
            end
            set_src(src, 1'b1, base + DW'(i), (i == n - 1));
            wait_hs(src);
        end
        set_src(src, 1'b0, '0, 1'b0);
    endtask

    // Packet-level prediction of what the packer receives.
    task automatic model_pkt(input int src, input int n, input int stall_k, input logic [DW-1:0] base);
        int    k;
        bit    bad;
        beat_t b;
        k   = (stall_k > 0) ? stall_k : ((n < ND) ? n : ND);
        bad = (stall_k > 0) || (n != ND);
        for (int i = 0; i < ND; i++) begin
            b.data = (i < k) ? base + DW'(i) : '0;
            b.last = (i == ND - 1);
            b.user = (src == 1);
            exp_q.push_back(b);
        end
        m_pkt[src] = (m_pkt[src] + 1) % 65536;
        if (bad && m_err < 255) m_err++;
        m_last = (src == 1);
    endtask

    task automatic wait_idle();
        int quiet, t;
        quiet = 0;
        t = 0;
        while (quiet < 3 && t < 4000) begin
            @(negedge clk);
            t++;
            if (led == 3'd0 && !m_tvalid) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check("idle_timeout", 64'(led), 64'(0));
    endtask

    task automatic compare_all(input string tag);
        int n;
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        check({tag, "_nbeats"}, 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, 64'(act_q[i].data), 64'(exp_q[i].data));
            check({tag, "_last"}, 64'(act_q[i].last), 64'(exp_q[i].last));
            check({tag, "_user"}, 64'(act_q[i].user), 64'(exp_q[i].user));
        end
        check({tag, "_pkt0"}, 64'(pkt0), 64'(m_pkt[0]));
        check({tag, "_pkt1"}, 64'(pkt1), 64'(m_pkt[1]));
        check({tag, "_err"},  64'(errc), 64'(m_err));
        $display("txn %s: beats=%0d pkt0=%0d pkt1=%0d err=%0d", tag, act_q.size(), pkt0, pkt1, errc);
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 64'(m_tvalid), 64'(0));
        check({tag, "_tlast"},  64'(m_tlast),  64'(0));
        check({tag, "_tuser"},  64'(m_tuser),  64'(0));
        check({tag, "_tdata"},  64'(m_tdata),  64'(0));
        check({tag, "_pkt0"},   64'(pkt0),     64'(0));
        check({tag, "_pkt1"},   64'(pkt1),     64'(0));
        check({tag, "_err"},    64'(errc),     64'(0));
        check({tag, "_led"},    64'(led),      64'(0));
        check({tag, "_rdy0"},   64'(s0_tready), 64'(0));
        check({tag, "_rdy1"},   64'(s1_tready), 64'(0));
    endtask

    // m00 monitor: captures accepted beats, checks hold-under-backpressure,
    // and measures idle cycles between a final beat and the next packet.
    bit    prev_stall;
    beat_t prev_beat;
    bit    gap_on;
    int    gap_cnt;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            gap_on     = 1'b0;
            gap_cnt    = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_tvalid), 64'(1));
                check("hold_data",  64'(m_tdata),  64'(prev_beat.data));
                check("hold_last",  64'(m_tlast),  64'(prev_beat.last));
                check("hold_user",  64'(m_tuser),  64'(prev_beat.user));
            end
            if (gap_on) begin
                if (m_tvalid) begin
                    gap_q.push_back(gap_cnt);
                    gap_on = 1'b0;
                end else begin
                    gap_cnt++;
                end
            end
            if (m_tvalid && m_tready) begin
                act_q.push_back('{data: m_tdata, last: m_tlast, user: m_tuser});
                if (m_tlast) begin
                    gap_on  = 1'b1;
                    gap_cnt = 0;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = '{data: m_tdata, last: m_tlast, user: m_tuser};
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(3, 0) != 0);
                default: m_tready = ~m_tready;
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int s, j0, j1, n, stall_k, nstall;
        logic [DW-1:0] base;

        rst = 1'b1;
        set_src(0, 1'b0, '0, 1'b0);
        set_src(1, 1'b0, '0, 1'b0);
        m_pkt[0] = 0; m_pkt[1] = 0; m_err = 0; m_last = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        // Both sources always valid: grants alternate, starting with s00.
        rmode = 0;
        gap_q.delete();
        j0 = 0; j1 = 0;
        for (int p = 0; p < 4; p++) begin
            s = m_last ? 0 : 1;
            if (s == 0) begin model_pkt(0, 4, 0, 32'h100 + 32'h10 * j0); j0++; end
            else        begin model_pkt(1, 4, 0, 32'h200 + 32'h10 * j1); j1++; end
        end
        fork
            begin drive_pkt(0, 4, 0, 0, 32'h100); drive_pkt(0, 4, 0, 0, 32'h110); end
            begin drive_pkt(1, 4, 0, 0, 32'h200); drive_pkt(1, 4, 0, 0, 32'h210); end
        join
        wait_idle();
        compare_all("round_robin");
        // Final beat, GAP_CYCLES gap, one arbitration cycle, one output stage.
        check("rr_ngaps", 64'(gap_q.size() >= 3), 64'(1));
        for (int i = 0; i < 3 && i < gap_q.size(); i++)
            check("rr_gap", 64'(gap_q[i]), 64'(GAPC + 2));

        model_pkt(0, 4, 0, 32'h11);
        drive_pkt(0, 4, 0, 0, 32'h11);
        wait_idle();
        compare_all("s00_normal");

        model_pkt(1, 2, 0, 32'hA0);
        drive_pkt(1, 2, 0, 0, 32'hA0);
        wait_idle();
        compare_all("s01_early_tlast");

        model_pkt(0, 6, 0, 32'hB0);
        drive_pkt(0, 6, 0, 0, 32'hB0);
        wait_idle();
        compare_all("s00_overlong");

        model_pkt(0, 4, 1, 32'hC0);
        drive_pkt(0, 4, 1, 0, 32'hC0);
        wait_idle();
        compare_all("s00_watchdog");

        // Bubble just under the watchdog limit must not abort the packet.
        model_pkt(1, 4, 0, 32'hF0);
        set_src(1, 1'b1, 32'hF0, 1'b0);
        wait_hs(1);
        set_src(1, 1'b0, '0, 1'b0);
        repeat (MAXS - 8) @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++) begin
            set_src(1, 1'b1, 32'hF0 + DW'(i), (i == 3));
            wait_hs(1);
        end
        set_src(1, 1'b0, '0, 1'b0);
        wait_idle();
        compare_all("long_bubble");

        // Randomized packets under random backpressure.
        rmode  = 1;
        nstall = 0;
        for (int it = 0; it < 40; it++) begin
            s       = $urandom_range(1, 0);
            stall_k = 0;
            if ($urandom_range(9, 0) == 0 && nstall < 2) begin
                stall_k = $urandom_range(3, 1);
                n       = 4;
                nstall++;
            end else begin
                n = ($urandom_range(1, 0) == 0) ? 4 : $urandom_range(6, 1);
            end
            base = $urandom;
            model_pkt(s, n, stall_k, base);
            drive_pkt(s, n, stall_k, 3, base);
            wait_idle();
            compare_all($sformatf("rand%0d_s%0d_n%0d_k%0d", it, s, n, stall_k));
        end

        // Reset mid-packet while m00 tready toggles.
        rmode = 2;
        set_src(0, 1'b1, 32'hD0, 1'b0);
        wait_hs(0);
        set_src(0, 1'b1, 32'hD1, 1'b0);
        wait_hs(0);
        set_src(0, 1'b1, 32'hD2, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_src(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check_reset_outputs("midpkt_reset");
        act_q.delete();
        exp_q.delete();
        m_pkt[0] = 0; m_pkt[1] = 0; m_err = 0; m_last = 1'b1;
        @(posedge clk); #1;

        rmode = 1;
        model_pkt(1, 4, 0, 32'hE0);
        drive_pkt(1, 4, 0, 2, 32'hE0);
        wait_idle();
        compare_all("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
